// File: rtl/matmul_pkg.sv
// matmul_pkg: shared loader/core/drain types and width helpers.
package matmul_pkg;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

    function automatic int n_slots(int rows, int cols);
        return rows * cols;
    endfunction

    // Accumulator width for a dot product of length c over w_a x w_b products.
    function automatic int w_c(int w_a, int w_b, int c);
        return w_a + w_b + $clog2(c);
    endfunction

    function automatic int idx_width(int n_a, int n_b);
        int m;
        m = (n_a > n_b) ? n_a : n_b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/matmul_loader.sv
// matmul_loader: packs a valid/ready element stream (A then B, row-major) into
// flattened A/B buses and holds them under ab_valid until ab_ready.
module matmul_loader
    import matmul_pkg::*;
#(
    parameter int R1   = 2,
    parameter int C1   = 2,
    parameter int R2   = 2,
    parameter int C2   = 2,
    parameter int W_A  = 3,
    parameter int W_B  = 3,
    parameter int W_IN = (W_A > W_B) ? W_A : W_B
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [W_IN-1:0]       s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [R1*C1*W_A-1:0]  A,
    output logic [R2*C2*W_B-1:0]  B,
    output logic                  ab_valid,
    input  logic                  ab_ready,
    output logic                  err,
    output logic                  err_sticky
);

    localparam int N_A = n_slots(R1, C1);
    localparam int N_B = n_slots(R2, C2);
    localparam int IW  = idx_width(N_A, N_B);

    if (C1 != R2) begin : g_dim_chk
        $fatal(1, "matmul_loader: C1 must equal R2");
    end

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n;
    logic [W_A-1:0]  a_mem [N_A];
    logic [W_B-1:0]  b_mem [N_B];
    logic            wa, wb, err_n, beat, a_end, b_end;

    assign s_ready  = (state != HOLD);
    assign ab_valid = (state == HOLD);
    assign beat     = s_valid & s_ready;
    assign a_end    = (idx == IW'(N_A - 1));
    assign b_end    = (idx == IW'(N_B - 1));

    for (genvar k = 0; k < N_A; k++) begin : g_pack_a
        assign A[k*W_A +: W_A] = a_mem[k];
    end
    for (genvar k = 0; k < N_B; k++) begin : g_pack_b
        assign B[k*W_B +: W_B] = b_mem[k];
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        wa      = 1'b0;
        wb      = 1'b0;
        err_n   = 1'b0;
        case (state)
            LOAD_A: if (beat) begin
                if (s_last) begin
                    err_n   = 1'b1;
                    idx_n   = '0;
                end else begin
                    wa      = 1'b1;
                    state_n = a_end ? LOAD_B : LOAD_A;
                    idx_n   = a_end ? '0 : idx + IW'(1);
                end
            end
            LOAD_B: if (beat) begin
                // Only the last slot with s_last completes a frame; any other s_last mix is a framing error.
                if (b_end && s_last) begin
                    wb      = 1'b1;
                    state_n = HOLD;
                    idx_n   = '0;
                end else if (b_end || s_last) begin
                    err_n   = 1'b1;
                    state_n = LOAD_A;
                    idx_n   = '0;
                end else begin
                    wb      = 1'b1;
                    idx_n   = idx + IW'(1);
                end
            end
            default: if (ab_ready) begin
                state_n = LOAD_A;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= LOAD_A;
            idx        <= '0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            for (int i = 0; i < N_A; i++) a_mem[i] <= '0;
            for (int i = 0; i < N_B; i++) b_mem[i] <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            err        <= err_n;
            err_sticky <= err_sticky | err_n;
            if (wa) a_mem[idx] <= s_data[W_A-1:0];
            if (wb) b_mem[idx] <= s_data[W_B-1:0];
        end
    end

endmodule

// File: tb/tb_matmul_loader.sv
// tb_matmul_loader: table-driven and randomized frame checks for matmul_loader.
module tb_matmul_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [11:0] A, B;
    logic        ab_valid;
    logic        ab_ready = 1'b0;
    logic        err, err_sticky;

    int tests = 0;
    int fails = 0;
    bit exp_sticky = 1'b0;

    always #5 clk = ~clk;

    matmul_loader dut (
        .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .A(A), .B(B), .ab_valid(ab_valid), .ab_ready(ab_ready),
        .err(err), .err_sticky(err_sticky)
    );

    // d: beat data (beat k in d[k]); n: beats sent; lp: beat carrying s_last (-1 none)
    typedef struct {
        logic [7:0][2:0] d;
        int              n;
        int              lp;
        bit              bub;
        int              hold;
        bit              v;
        logic [11:0]     ea;
        logic [11:0]     eb;
    } vec_t;

    function automatic vec_t mk(logic [23:0] d, int n, int lp, bit bub, int hold,
                                bit v, logic [11:0] ea, logic [11:0] eb);
        vec_t r;
        r.d = d; r.n = n; r.lp = lp; r.bub = bub; r.hold = hold;
        r.v = v; r.ea = ea; r.eb = eb;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_frame(vec_t v, bit rnd_rdy);
        for (int k = 0; k < v.n; k++) begin
            if (v.bub) begin
                @(negedge clk);
                s_valid = 1'b0;
                @(posedge clk);
            end
            @(negedge clk);
            chk("s_ready_load", s_ready, 1'b1);
            s_valid  = 1'b1;
            s_data   = v.d[k];
            s_last   = (k == v.lp);
            ab_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        s_valid  = 1'b0;
        s_last   = 1'b0;
        ab_ready = 1'b0;
        if (!v.v) exp_sticky = 1'b1;
        chk("err_pulse", err, !v.v);
        chk("ab_valid_after", ab_valid, v.v);
        chk("err_sticky", err_sticky, exp_sticky);
        if (v.v) begin
            chk("A", A, v.ea);
            chk("B", B, v.eb);
            chk("s_ready_hold", s_ready, 1'b0);
            for (int h = 0; h < v.hold; h++) begin
                // stray source data during HOLD must not be consumed
                s_valid = 1'b1;
                s_data  = 3'($urandom);
                @(negedge clk);
                chk("hold_valid", ab_valid, 1'b1);
                chk("hold_A", A, v.ea);
                chk("hold_B", B, v.eb);
            end
            s_valid  = 1'b0;
            ab_ready = 1'b1;
            @(negedge clk);
            ab_ready = 1'b0;
            chk("hs_valid", ab_valid, 1'b0);
            chk("hs_ready", s_ready, 1'b1);
        end else begin
            @(negedge clk);
            chk("err_clear", err, 1'b0);
            chk("err_no_valid", ab_valid, 1'b0);
            chk("err_ready", s_ready, 1'b1);
        end
    endtask

    // Reference packing: element k occupies bits [3k+2:3k], i.e. weight 8**k.
    function automatic logic [11:0] pack4(logic [7:0][2:0] d, int base);
        int acc = 0;
        for (int k = 0; k < 4; k++) acc += int'(d[base + k]) * (8 ** k);
        return 12'(acc);
    endfunction

    vec_t tbl[7];
    vec_t rv;

    initial begin
        tbl[0] = mk(24'o07654321, 8,  7, 1'b0, 10, 1'b1, 12'h8D1, 12'h1F5);
        tbl[1] = mk(24'o11117777, 8,  7, 1'b0,  2, 1'b1, 12'hFFF, 12'h249);
        tbl[2] = mk(24'o07654321, 8,  7, 1'b1,  2, 1'b1, 12'h8D1, 12'h1F5);
        tbl[3] = mk(24'o00000321, 3,  2, 1'b0,  0, 1'b0, 12'h000, 12'h000);
        tbl[4] = mk(24'o22223333, 8,  7, 1'b0,  2, 1'b1, 12'h6DB, 12'h492);
        tbl[5] = mk(24'o76543210, 8, -1, 1'b0,  0, 1'b0, 12'h000, 12'h000);
        tbl[6] = mk(24'o07654321, 8,  7, 1'b0,  2, 1'b1, 12'h8D1, 12'h1F5);

        #2;
        chk("rst_A", A, 12'h0);
        chk("rst_B", B, 12'h0);
        chk("rst_valid", ab_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_sticky", err_sticky, 1'b0);
        chk("rst_ready", s_ready, 1'b1);
        @(negedge clk);
        rstn = 1'b1;

        for (int t = 0; t < 7; t++) run_frame(tbl[t], 1'b0);

        for (int t = 0; t < 30; t++) begin
            int kind;
            rv.d   = 24'($urandom);
            rv.bub = 1'($urandom_range(0, 1));
            rv.hold = $urandom_range(0, 3);
            kind   = $urandom_range(0, 5);
            if (kind == 0) begin
                rv.lp = $urandom_range(0, 6);
                rv.n  = rv.lp + 1;
            end else if (kind == 1) begin
                rv.lp = -1;
                rv.n  = 8;
            end else begin
                rv.lp = 7;
                rv.n  = 8;
            end
            rv.v  = (rv.n == 8) && (rv.lp == 7);
            rv.ea = pack4(rv.d, 0);
            rv.eb = pack4(rv.d, 4);
            run_frame(rv, 1'b1);
        end

        // Reset in the middle of a frame after 5 accepted beats.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = tbl[0].d[k];
            @(posedge clk);
        end
        #2;
        rstn    = 1'b0;
        s_valid = 1'b0;
        #1;
        exp_sticky = 1'b0;
        chk("mid_rst_A", A, 12'h0);
        chk("mid_rst_B", B, 12'h0);
        chk("mid_rst_valid", ab_valid, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_sticky", err_sticky, 1'b0);
        chk("mid_rst_ready", s_ready, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        run_frame(tbl[0], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matmul_loader.md
Name: matmul_loader

Overview:
- Upstream feeder for the matrix-multiply core.
- Accepts matrix elements as a valid/ready stream: first A in row-major order, then B in row-major order.
- Packs the elements into the flattened A/B buses the core consumes, then holds them stable with ab_valid until the consumer takes them with ab_ready.
- Checks stream framing with s_last. Framing errors drop the partial load and resynchronise the loader.

Parameters:
- R1, default 2: rows of A
- C1, default 2: cols of A; must equal R2
- R2, default 2: rows of B
- C2, default 2: cols of B
- W_A, default 3: A element width
- W_B, default 3: B element width
- W_IN, default max(W_A,W_B): stream data width

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- s_data  in  W_IN  element; A beats use bits [W_A-1:0], B beats use bits [W_B-1:0]
- s_valid  in  1  element valid
- s_last  in  1  marks final B element of a frame
- s_ready  out  1  loader can accept an element
- A  out  R1*C1*W_A  packed A; element k=i*C1+j at bits [k*W_A +: W_A]
- B  out  R2*C2*W_B  packed B; element k=i*C2+j at bits [k*W_B +: W_B]
- ab_valid  out  1  A/B complete and stable
- ab_ready  in  1  consumer accepts A/B (consumer drives the core's cen from ab_valid&ab_ready)
- err  out  1  one-cycle pulse on framing error
- err_sticky  out  1  set on any error; cleared only by reset

Behaviour:
- Reset (rstn=0, async): state=LOAD_A, idx=0, A=0, B=0, ab_valid=0, err=0, err_sticky=0. A reset mid-frame discards all partial data.
- Beat: s_valid & s_ready sampled on a rising edge.
- s_ready = (state != HOLD). It is combinational from state only and never depends on s_valid.
- States:
  - LOAD_A: each beat writes slot idx of A, then idx++. The beat with idx==R1*C1-1 goes to LOAD_B with idx=0.
  - LOAD_B: each beat writes slot idx of B, then idx++. The beat with idx==R2*C2-1 and s_last=1 goes to HOLD; ab_valid=1 from the next cycle.
  - HOLD: ab_valid=1; A and B frozen; s_ready=0. ab_ready=1 goes to LOAD_A with idx=0 and ab_valid=0 next cycle.
- Latency:
  - ab_valid rises 1 cycle after the final B beat.
  - After the ab_valid&ab_ready handshake, s_ready=1 on the next cycle, so at least one idle cycle separates frames.
- Framing errors (err=1 for one cycle, err_sticky set):
  - s_last=1 on any beat other than the final B beat: the beat is consumed and discarded; go to LOAD_A with idx=0.
  - Final B beat arrives with s_last=0: the beat is discarded; go to LOAD_A with idx=0.
  - In both cases ab_valid stays 0. Register contents are don't-care and get overwritten by the next frame.
- ab_ready while ab_valid=0 is ignored.
- s_valid while in HOLD is not consumed; the element must be held by the source.
- Slots not yet written in the current frame keep their previous values. Only ab_valid qualifies A/B.
- idx width is clog2(max(R1*C1,R2*C2)). It never wraps past the last slot because the state changes first.
- Elaboration check: C1 != R2 is a fatal error.

Decomposition:
- Shared package matmul_pkg holds:
  - state enum {LOAD_A, LOAD_B, HOLD}
  - localparams N_A=R1*C1, N_B=R2*C2, W_C=W_A+W_B+clog2(C1), so the loader, the core and the result drain agree on widths
- No sub-module: one FSM, one index counter and two indexed register banks.

Test Plan:
Default parameters (2x2x2x2, W_A=W_B=3) throughout.
- Nominal frame: stream 1,2,3,4,5,6,7,0 with s_last on beat 8, ab_ready=0 -> ab_valid=1 the cycle after beat 8; A=12'h8D1, B=12'h1F5; s_ready=0; outputs stable for 10 cycles.
- Handshake and back-to-back frames:
  - ab_ready=1 for one cycle -> ab_valid=0 and s_ready=1 next cycle.
  - Second frame 7,7,7,7,1,1,1,1 -> A=12'hFFF, B=12'h249.
- Source bubbles: s_valid toggling 1010... with the same data as the nominal frame -> identical A/B; ab_valid only after the 8th accepted beat.
- Early s_last on beat 3:
  - err pulses 1 cycle; err_sticky=1; no ab_valid.
  - A following clean frame loads correctly.
- Missing s_last on beat 8:
  - err pulse; no ab_valid.
  - A following clean frame yields ab_valid.
- Reset mid-frame: assert rstn=0 after 5 beats -> all outputs 0 immediately (async); after release a full frame loads correctly.
